// File: rtl/send_cmd_scheduler_if.sv
// Request channel into the send command scheduler: valid/ready handshake
// carrying the target engine select and the DDR start address.
interface send_cmd_scheduler_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_port;
  logic [24:0] req_addr;

  modport master (output req_valid, output req_port, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_port, input req_addr, output req_ready);
endinterface

// File: rtl/send_cmd_scheduler.sv
// Send command scheduler: queues send requests and dispatches them strictly
// in order to two send engines, one request per cycle at most.
// Optional feature macro: SEND_TIMEOUT_EN adds a per-channel WAIT watchdog
// that forces the channel back to IDLE and raises a sticky timeout_err bit.
//
// Channel FSM states:
//   state    | meaning
//   ST_IDLE  | channel free, may accept a dispatch from the queue head
//   ST_ISSUE | cmd_send high for this single cycle
//   ST_WAIT  | waiting for the engine done pulse (or watchdog expiry)
module send_cmd_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                reset,
  send_cmd_scheduler_if.slave req,
  input  logic                ddr_ready,
  output logic [24:0]         send_1_start_ram_addr,
  output logic [24:0]         send_2_start_ram_addr,
  output logic                send_1_cmd_send,
  output logic                send_2_cmd_send,
  input  logic                send_1_done,
  input  logic                send_2_done,
  output logic [4:0]          fifo_level,
  output logic                busy,
  output logic [1:0]          timeout_err,
  input  logic                err_clear
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} ch_state_t;

  logic [25:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              ready_en;
  logic              push;
  logic              pop;
  logic [25:0]       head;
  logic              head_port;
  logic [24:0]       head_addr;
  logic              dispatch;
  ch_state_t         ch_state [2];
  logic [1:0]        cmd_send;
  logic [1:0][24:0]  start_addr;
  logic [1:0]        done_v;
  logic [1:0]        expire;

  assign done_v    = {send_2_done, send_1_done};
  assign head      = mem[rd_ptr];
  assign head_port = head[25];
  assign head_addr = head[24:0];

  // ready only depends on registered state so a same-cycle pop cannot unblock a full queue
  assign req.req_ready = ready_en && (fifo_level < 5'(FIFO_DEPTH));
  assign push          = req.req_valid && req.req_ready;
  assign dispatch      = (fifo_level != 5'd0) && ddr_ready && (ch_state[head_port] == ST_IDLE);
  assign pop           = dispatch;

  assign busy = (fifo_level != 5'd0) || (ch_state[0] != ST_IDLE) || (ch_state[1] != ST_IDLE);

  assign send_1_cmd_send       = cmd_send[0];
  assign send_2_cmd_send       = cmd_send[1];
  assign send_1_start_ram_addr = start_addr[0];
  assign send_2_start_ram_addr = start_addr[1];

  // Holds req_ready low until the first clock after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  // Queue storage; entries are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {req.req_port, req.req_addr};
  end

  // Queue pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= 5'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 5'd1;
        2'b01:   fifo_level <= fifo_level - 5'd1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Per-channel IDLE/ISSUE/WAIT sequencing with registered cmd_send and address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < 2; c++) ch_state[c] <= ST_IDLE;
      cmd_send   <= '0;
      start_addr <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        case (ch_state[c])
          ST_IDLE: begin
            cmd_send[c] <= 1'b0;
            if (dispatch && (head_port == 1'(c))) begin
              ch_state[c]   <= ST_ISSUE;
              cmd_send[c]   <= 1'b1;
              start_addr[c] <= head_addr;
            end
          end
          ST_ISSUE: begin
            cmd_send[c] <= 1'b0;
            ch_state[c] <= ST_WAIT;
          end
          ST_WAIT: begin
            cmd_send[c] <= 1'b0;
            if (done_v[c] || expire[c]) ch_state[c] <= ST_IDLE;
          end
          default: begin
            cmd_send[c] <= 1'b0;
            ch_state[c] <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SEND_TIMEOUT_EN
  logic [1:0][19:0] wait_cnt;
  logic [1:0]       err_q;

  // Watchdog expires on the last permitted WAIT cycle
  always_comb begin
    expire = '0;
    for (int c = 0; c < 2; c++)
      expire[c] = (ch_state[c] == ST_WAIT) && (wait_cnt[c] == 20'(TIMEOUT_CYCLES - 1));
  end

  // WAIT counters restart from zero on each WAIT entry; err_clear beats a new timeout
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      err_q    <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (ch_state[c] == ST_WAIT) wait_cnt[c] <= wait_cnt[c] + 20'd1;
        else                        wait_cnt[c] <= 20'd0;
      end
      if (err_clear) err_q <= '0;
      else           err_q <= err_q | (expire & ~done_v);
    end
  end

  assign timeout_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg  = err_clear ^ TIMEOUT_CYCLES[0];
  assign expire      = '0;
  assign timeout_err = 2'b00;
`endif

endmodule

// File: tb/tb_send_cmd_scheduler.sv
// Self-checking bench for send_cmd_scheduler: table of single-request round
// trips plus hand-written sequences for queue-full, in-order blocking,
// watchdog and mid-operation reset. A scoreboard queue holds every accepted
// request; each cmd_send pulse must match the oldest outstanding entry.
module tb_send_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        ddr_ready;
  logic        send_1_done, send_2_done, err_clear;
  logic [24:0] a1, a2;
  logic        c1, c2;
  logic [4:0]  lvl;
  logic        busy;
  logic [1:0]  terr;

  send_cmd_scheduler_if ifc();

  send_cmd_scheduler #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .req                   (ifc),
    .ddr_ready             (ddr_ready),
    .send_1_start_ram_addr (a1),
    .send_2_start_ram_addr (a2),
    .send_1_cmd_send       (c1),
    .send_2_cmd_send       (c2),
    .send_1_done           (send_1_done),
    .send_2_done           (send_2_done),
    .fifo_level            (lvl),
    .busy                  (busy),
    .timeout_err           (terr),
    .err_clear             (err_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int cnt1 = 0;
  int cnt2 = 0;
  logic [25:0] sb_q[$];

  typedef struct {
    logic        port;
    logic [24:0] addr;
    int          delay;
    logic        exp_c1;
    logic        exp_c2;
  } vec_t;
  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sb_pop(input logic p, input logic [24:0] a);
    logic [25:0] e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_mis++;
      $display("FAIL sb_underflow: cmd on port %0d addr 0x%0h, expected no cmd", p, a);
    end else begin
      e = sb_q.pop_front();
      check("sb_port", 32'(p), 32'(e[25]));
      check("sb_addr", 32'(a), 32'(e[24:0]));
    end
  endtask

  // scoreboard monitor, sampled on the inactive edge
  always @(negedge clk) begin
    if (!reset) begin
      if (c1 || c2) check("cmd_exclusive", 32'(c1 & c2), 32'd0);
      if (c1) begin cnt1++; sb_pop(1'b0, a1); end
      if (c2) begin cnt2++; sb_pop(1'b1, a2); end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // offer a request, wait (bounded) for acceptance; returns in the cycle after accept
  task automatic push(input logic p, input logic [24:0] a);
    int n;
    n = 0;
    ifc.req_valid = 1'b1;
    ifc.req_port  = p;
    ifc.req_addr  = a;
    while (ifc.req_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    if (ifc.req_ready !== 1'b1) begin
      n_cmp++;
      n_mis++;
      $display("FAIL push_timeout: req_ready stuck at %0b, expected 1", ifc.req_ready);
    end else begin
      sb_q.push_back({p, a});
    end
    step();
    ifc.req_valid = 1'b0;
  endtask

  task automatic pulse_done(input int ch);
    if (ch == 0) send_1_done = 1'b1;
    else         send_2_done = 1'b1;
    step();
    send_1_done = 1'b0;
    send_2_done = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  int n1, n2;

  initial begin
    vecs[0] = '{1'b0, 25'h0001000, 0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 25'h1FFFFFF, 3, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 25'h0000000, 5, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 25'h0ABCDEF, 1, 1'b0, 1'b1};

    reset = 1'b1; ddr_ready = 1'b1; send_1_done = 1'b0; send_2_done = 1'b0; err_clear = 1'b0;
    ifc.req_valid = 1'b0; ifc.req_port = 1'b0; ifc.req_addr = '0;
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check("rst_ready", 32'(ifc.req_ready), 32'd0);
    check("rst_level", 32'(lvl), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_cmd",   32'({c1, c2}), 32'd0);
    check("rst_addr1", 32'(a1), 32'd0);
    check("rst_addr2", 32'(a2), 32'd0);
    check("rst_terr",  32'(terr), 32'd0);
    reset = 1'b0;
    check("ready_before_clk", 32'(ifc.req_ready), 32'd0);
    step();
    check("ready_after_clk", 32'(ifc.req_ready), 32'd1);

    // table: single request round trips, 2-cycle latency, busy until 1 cycle after done
    for (int i = 0; i < 4; i++) begin
      push(vecs[i].port, vecs[i].addr);
      check("vec_level1", 32'(lvl), 32'd1);
      check("vec_no_early_cmd", 32'({c1, c2}), 32'd0);
      step();
      check("vec_c1", 32'(c1), 32'(vecs[i].exp_c1));
      check("vec_c2", 32'(c2), 32'(vecs[i].exp_c2));
      check("vec_addr", 32'(vecs[i].port ? a2 : a1), 32'(vecs[i].addr));
      step();
      check("vec_single_pulse", 32'({c1, c2}), 32'd0);
      repeat (vecs[i].delay) step();
      check("vec_busy_wait", 32'(busy), 32'd1);
      pulse_done(vecs[i].port ? 1 : 0);
      check("vec_busy_clear", 32'(busy), 32'd0);
      check("vec_level0", 32'(lvl), 32'd0);
    end

    // full queue with ddr gated, then release
    ddr_ready = 1'b0;
    n1 = cnt1; n2 = cnt2;
    push(1'b0, 25'h0000100);
    push(1'b1, 25'h0000200);
    push(1'b0, 25'h0000300);
    push(1'b1, 25'h0000400);
    check("full_level", 32'(lvl), 32'd4);
    check("full_ready", 32'(ifc.req_ready), 32'd0);
    ifc.req_valid = 1'b1; ifc.req_port = 1'b0; ifc.req_addr = 25'h0000500;
    repeat (3) begin
      check("fifth_ready", 32'(ifc.req_ready), 32'd0);
      step();
    end
    ifc.req_valid = 1'b0;
    check("gated_no_cmd", 32'(cnt1 + cnt2 - n1 - n2), 32'd0);
    check("gated_level", 32'(lvl), 32'd4);
    ddr_ready = 1'b1;
    check("full_pop_no_ready", 32'(ifc.req_ready), 32'd0);
    step();
    check("rel_c1", 32'(c1), 32'd1);
    check("rel_level3", 32'(lvl), 32'd3);
    check("rel_ready", 32'(ifc.req_ready), 32'd1);
    step();
    check("rel_c2", 32'(c2), 32'd1);
    check("rel_level2", 32'(lvl), 32'd2);
    step();
    check("blocked_cmd", 32'({c1, c2}), 32'd0);
    repeat (3) step();
    check("blocked_level", 32'(lvl), 32'd2);
    pulse_done(0);
    repeat (2) step();
    pulse_done(1);
    repeat (3) step();
    send_1_done = 1'b1; send_2_done = 1'b1;
    step();
    send_1_done = 1'b0; send_2_done = 1'b0;
    wait_idle();

    // in-order blocking; done during ISSUE is ignored
    push(1'b0, 25'h00000A0);
    step();
    step();
    push(1'b0, 25'h00000B0);
    push(1'b1, 25'h00000C0);
    n2 = cnt2;
    repeat (4) step();
    check("inorder_no_c", 32'(cnt2 - n2), 32'd0);
    check("inorder_level", 32'(lvl), 32'd2);
    send_1_done = 1'b1;
    step();
    send_1_done = 1'b0;
    check("inorder_gap", 32'({c1, c2}), 32'd0);
    step();
    check("inorder_b_cmd", 32'(c1), 32'd1);
    check("inorder_b_addr", 32'(a1), 32'h00000B0);
    send_1_done = 1'b1;
    step();
    send_1_done = 1'b0;
    check("inorder_c_cmd", 32'(c2), 32'd1);
    check("inorder_c_addr", 32'(a2), 32'h00000C0);
    check("inorder_level0", 32'(lvl), 32'd0);
    step();
    pulse_done(1);
    repeat (2) step();
    check("issue_done_ignored", 32'(busy), 32'd1);
    pulse_done(0);
    check("inorder_idle", 32'(busy), 32'd0);

    // WAIT watchdog
    push(1'b0, 25'h0123456);
    step();
    step();
    repeat (15) step();
    check("wd_busy_last", 32'(busy), 32'd1);
    check("wd_terr_last", 32'(terr), 32'd0);
    step();
`ifdef SEND_TIMEOUT_EN
    check("wd_expired_idle", 32'(busy), 32'd0);
    check("wd_terr_set", 32'(terr), 32'd1);
    repeat (3) step();
    check("wd_terr_sticky", 32'(terr), 32'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("wd_terr_clear", 32'(terr), 32'd0);
`else
    check("wd_no_expiry", 32'(busy), 32'd1);
    check("wd_terr_zero", 32'(terr), 32'd0);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    check("wd_terr_still0", 32'(terr), 32'd0);
    pulse_done(0);
    check("wd_done_idle", 32'(busy), 32'd0);
`endif

    // reset mid-operation: engine 2 in WAIT, two entries queued
    push(1'b1, 25'h0000777);
    step();
    step();
    ddr_ready = 1'b0;
    push(1'b0, 25'h0000888);
    push(1'b1, 25'h0000999);
    check("pre_rst_level", 32'(lvl), 32'd2);
    reset = 1'b1;
    #1;
    sb_q.delete();
    check("midrst_level", 32'(lvl), 32'd0);
    check("midrst_ready", 32'(ifc.req_ready), 32'd0);
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_cmd",   32'({c1, c2}), 32'd0);
    check("midrst_addr1", 32'(a1), 32'd0);
    check("midrst_addr2", 32'(a2), 32'd0);
    check("midrst_terr",  32'(terr), 32'd0);
    step();
    step();
    reset = 1'b0;
    ddr_ready = 1'b1;
    n1 = cnt1; n2 = cnt2;
    repeat (10) step();
    check("postrst_no_cmd", 32'(cnt1 + cnt2 - n1 - n2), 32'd0);
    check("postrst_busy", 32'(busy), 32'd0);
    push(1'b0, 25'h0000ABC);
    step();
    check("postrst_new_cmd", 32'(c1), 32'd1);
    check("postrst_new_addr", 32'(a1), 32'h0000ABC);
    step();
    pulse_done(0);
    check("postrst_idle", 32'(busy), 32'd0);

    step();
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    n_mis++;
    $display("FAIL watchdog: simulation time limit reached, expected bench completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $fatal(1, "time limit");
  end

endmodule
